// File: rtl/bsg_counter_up_down_pkg.sv
// Shared types and width helpers for the multi-channel up/down counter.
package bsg_counter_up_down_pkg;

  typedef enum logic [1:0] {
    e_cnt_ok,
    e_cnt_over,
    e_cnt_under
  } bsg_cnt_status_e;

  function automatic int bsg_width(input int x);
    return $clog2(x + 1);
  endfunction

  // Two guard bits: one for the carry past max, one for the sign.
  function automatic int raw_width(input int ptr_w);
    return ptr_w + 2;
  endfunction

endpackage

// File: rtl/bsg_counter_up_down_sat_chan.sv
// One counter channel: register, clamp/wrap arithmetic and sticky error.
// Optional threshold flag when BSG_COUNTER_UP_DOWN_SAT_MULTI_THRESH_EN is defined.
module bsg_counter_up_down_sat_chan
  import bsg_counter_up_down_pkg::*;
#(
  parameter int max_val_p  = 15,
  parameter int init_val_p = 0,
  parameter int max_step_p = 1,
  parameter int saturate_p = 1,
  localparam int step_width_lp = bsg_width(max_step_p),
  localparam int ptr_width_lp  = bsg_width(max_val_p)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    clear_i,
  input  logic [step_width_lp-1:0] up_i,
  input  logic [step_width_lp-1:0] down_i,
  input  logic                    clear_err_i,
`ifdef BSG_COUNTER_UP_DOWN_SAT_MULTI_THRESH_EN
  input  logic [ptr_width_lp-1:0] thresh_i,
  output logic                    above_o,
`endif
  output logic [ptr_width_lp-1:0] count_o,
  output logic                    zero_o,
  output logic                    full_o,
  output logic                    err_o
);

  localparam int rw_lp = raw_width(ptr_width_lp);
  localparam logic [ptr_width_lp-1:0] init_lp = ptr_width_lp'(init_val_p);
  localparam logic [ptr_width_lp-1:0] max_lp  = ptr_width_lp'(max_val_p);
  localparam logic signed [rw_lp-1:0] max_s_lp = rw_lp'(max_val_p);

  logic [ptr_width_lp-1:0] count_q, count_d;
  logic                    err_q, err_d;
  logic signed [rw_lp-1:0] raw;
  logic [ptr_width_lp-1:0] next_cnt;
  bsg_cnt_status_e         status;

  assign raw = signed'(rw_lp'(count_q))
             + signed'(rw_lp'(up_i))
             - signed'(rw_lp'(down_i));

  always_comb begin
    status = e_cnt_ok;
    unique case (1'b1)
      raw[rw_lp-1]:     status = e_cnt_under;
      (raw > max_s_lp): status = e_cnt_over;
      default:          status = e_cnt_ok;
    endcase
  end

  always_comb begin
    next_cnt = raw[ptr_width_lp-1:0];
    if (saturate_p != 0) begin
      unique case (status)
        e_cnt_over:  next_cnt = max_lp;
        e_cnt_under: next_cnt = '0;
        default:     next_cnt = raw[ptr_width_lp-1:0];
      endcase
    end
  end

  // A clear reloads the count but leaves the error history alone.
  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (clear_i) begin
      count_d = init_lp;
    end else begin
      count_d = next_cnt;
      err_d   = (status != e_cnt_ok) | (err_q & ~clear_err_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= init_lp;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

`ifdef BSG_COUNTER_UP_DOWN_SAT_MULTI_THRESH_EN
  logic above_q, above_d;

  assign above_d = (count_d >= thresh_i);

  always_ff @(posedge clk_i) begin
    if (reset_i) above_q <= 1'b0;
    else         above_q <= above_d;
  end

  assign above_o = above_q;
`endif

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);
  assign full_o  = (count_q == max_lp);
  assign err_o   = err_q;

endmodule

// File: rtl/bsg_counter_up_down_sat_multi.sv
// Array of independent saturating/wrapping up/down counters.
// Define BSG_COUNTER_UP_DOWN_SAT_MULTI_THRESH_EN to add thresh_i/above_o.
module bsg_counter_up_down_sat_multi
  import bsg_counter_up_down_pkg::*;
#(
  parameter int els_p      = 1,
  parameter int max_val_p  = 15,
  parameter int init_val_p = 0,
  parameter int max_step_p = 1,
  parameter int saturate_p = 1,
  localparam int step_width_lp = bsg_width(max_step_p),
  localparam int ptr_width_lp  = bsg_width(max_val_p)
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic [els_p-1:0]                 clear_i,
  input  logic [els_p*step_width_lp-1:0]   up_i,
  input  logic [els_p*step_width_lp-1:0]   down_i,
  input  logic [els_p-1:0]                 clear_err_i,
`ifdef BSG_COUNTER_UP_DOWN_SAT_MULTI_THRESH_EN
  input  logic [els_p*ptr_width_lp-1:0]    thresh_i,
  output logic [els_p-1:0]                 above_o,
`endif
  output logic [els_p*ptr_width_lp-1:0]    count_o,
  output logic [els_p-1:0]                 zero_o,
  output logic [els_p-1:0]                 full_o,
  output logic [els_p-1:0]                 err_o
);

  localparam int sw_lp = step_width_lp;
  localparam int pw_lp = ptr_width_lp;

  for (genvar i = 0; i < els_p; i++) begin : g_chan
    bsg_counter_up_down_sat_chan #(
      .max_val_p  (max_val_p),
      .init_val_p (init_val_p),
      .max_step_p (max_step_p),
      .saturate_p (saturate_p)
    ) u_chan (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .clear_i     (clear_i[i]),
      .up_i        (up_i[i*sw_lp +: sw_lp]),
      .down_i      (down_i[i*sw_lp +: sw_lp]),
      .clear_err_i (clear_err_i[i]),
`ifdef BSG_COUNTER_UP_DOWN_SAT_MULTI_THRESH_EN
      .thresh_i    (thresh_i[i*pw_lp +: pw_lp]),
      .above_o     (above_o[i]),
`endif
      .count_o     (count_o[i*pw_lp +: pw_lp]),
      .zero_o      (zero_o[i]),
      .full_o      (full_o[i]),
      .err_o       (err_o[i])
    );
  end

endmodule
